// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage.
// Keeps the PC, fetches one instruction at a time from imem
// over a req/rsp handshake and hands it to decode with a
// valid/ready handshake. The next PC is chosen from decode's
// next_pc_sel, the branch outcome, the immediates and rs1.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_req_valid    fetch request valid (S_REQ)
//   imem_req_ready    imem accepts the request
//   imem_addr         fetch address, always equal to pc
//   imem_rsp_valid    read data valid (taken only in S_WAIT)
//   imem_rdata        fetched instruction word
//   inst_encoding     instruction presented to decode
//   inst_valid        inst_encoding valid (S_DLVR)
//   inst_ready        decode retires the instruction; the
//                     next-PC inputs are valid this cycle
//   next_pc_sel       next-PC source select from decode
//   br_taken          branch condition result
//   jal_imm           sign-extended JAL offset
//   brch_imm          sign-extended branch offset
//   jalr_imm          sign-extended JALR offset
//   rs1_data          rs1 operand for JALR
//   pc                current PC
//   halted            fetch stopped (S_HALT)
//   misalign_err      sticky: retired to a misaligned PC
//   bus_err           sticky: imem response timeout

`ifndef PC_FROM_PC_PLUS_4
`define PC_FROM_PC_PLUS_4 3'd0
`endif
`ifndef PC_PLUS_JAL_IMM
`define PC_PLUS_JAL_IMM 3'd1
`endif
`ifndef PC_PLUS_BRCH_IMM
`define PC_PLUS_BRCH_IMM 3'd2
`endif
`ifndef NEXT_PC_FROM_RF
`define NEXT_PC_FROM_RF 3'd3
`endif

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_encoding,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [2:0]  next_pc_sel,
    input  logic        br_taken,
    input  logic [31:0] jal_imm,
    input  logic [31:0] brch_imm,
    input  logic [31:0] jalr_imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc,
    output logic        halted,
    output logic        misalign_err,
    output logic        bus_err
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be 4-byte aligned");
    end

    if (TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 8-bit wait timer");
    end

    localparam logic       TIMEOUT_EN  = (TIMEOUT_CYC != 0);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DLVR,
        S_HALT
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;
    logic [7:0]  timer_q;
    logic [7:0]  timer_d;
    logic        misalign_q;
    logic        misalign_d;
    logic        bus_err_q;
    logic        bus_err_d;

    logic        in_req;
    logic        in_wait;
    logic        in_dlvr;
    logic        req_fire;
    logic        rsp_fire;
    logic        retire;
    logic [7:0]  timer_inc;
    logic        timeout_hit;

    logic [31:0] pc_plus4;
    logic [31:0] jal_tgt;
    logic [31:0] brch_tgt;
    logic [31:0] jalr_sum;
    logic [31:0] jalr_tgt;
    logic        sel_jal;
    logic        sel_brch;
    logic        sel_rf;
    logic [31:0] next_pc;
    logic        next_pc_bad;

    // ---------------------------------------------------------
    // Handshake qualifiers
    // ---------------------------------------------------------
    assign in_req    = (state_q == S_REQ);
    assign in_wait   = (state_q == S_WAIT);
    assign in_dlvr   = (state_q == S_DLVR);
    assign req_fire  = in_req && imem_req_ready;
    // A response is only meaningful while a request is
    // outstanding; anything seen in other states is stale.
    assign rsp_fire  = in_wait && imem_rsp_valid;
    assign retire    = in_dlvr && inst_ready;
    assign timer_inc = timer_q + 8'd1;

    // The response wins if it shows up on the last allowed
    // wait cycle.
    assign timeout_hit = TIMEOUT_EN && in_wait
                      && !imem_rsp_valid
                      && (timer_inc == TIMEOUT_LIM);

    // ---------------------------------------------------------
    // Next-PC selection
    // ---------------------------------------------------------
    assign pc_plus4 = pc_q + 32'd4;
    assign jal_tgt  = pc_q + jal_imm;
    assign brch_tgt = pc_q + brch_imm;
    assign jalr_sum = rs1_data + jalr_imm;
    // JALR drops bit 0 before the alignment check, so only
    // bit 1 can still flag a misaligned JALR target.
    assign jalr_tgt = jalr_sum & ~32'h1;

    assign sel_jal  = (next_pc_sel == `PC_PLUS_JAL_IMM);
    assign sel_brch = (next_pc_sel == `PC_PLUS_BRCH_IMM);
    assign sel_rf   = (next_pc_sel == `NEXT_PC_FROM_RF);

    always_comb begin
        next_pc = pc_plus4;
        unique case (1'b1)
            sel_jal:  next_pc = jal_tgt;
            sel_brch: next_pc = br_taken ? brch_tgt
                                         : pc_plus4;
            sel_rf:   next_pc = jalr_tgt;
            default:  next_pc = pc_plus4;
        endcase
    end

    assign next_pc_bad = (next_pc[1:0] != 2'b00);

    // ---------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_DLVR;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end
            end
            S_DLVR: begin
                if (inst_ready) begin
                    state_d = next_pc_bad ? S_HALT
                                          : S_REQ;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // ---------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        halted         = 1'b0;
        unique case (state_q)
            S_REQ:   imem_req_valid = 1'b1;
            S_DLVR:  inst_valid     = 1'b1;
            S_HALT:  halted         = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------
    // Datapath next values
    // ---------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        timer_d    = timer_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;

        if (req_fire) begin
            timer_d = 8'd0;
        end else if (in_wait) begin
            timer_d = timer_inc;
        end

        if (rsp_fire) begin
            inst_d = imem_rdata;
        end

        // The faulty target is still committed so software
        // can see where control flow went wrong.
        if (retire) begin
            pc_d = next_pc;
            if (next_pc_bad) begin
                misalign_d = 1'b1;
            end
        end

        if (timeout_hit) begin
            bus_err_d = 1'b1;
        end
    end

    // ---------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            timer_q    <= 8'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            timer_q    <= timer_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign inst_encoding = inst_q;
    assign misalign_err  = misalign_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit.
// Inputs change and outputs are checked on the falling edge.

module tb_pc_fetch_unit;

    localparam logic [2:0] SEL_P4   = 3'd0;
    localparam logic [2:0] SEL_JAL  = 3'd1;
    localparam logic [2:0] SEL_BRCH = 3'd2;
    localparam logic [2:0] SEL_RF   = 3'd3;
    localparam logic [2:0] SEL_BAD  = 3'd7;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_encoding;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  next_pc_sel;
    logic        br_taken;
    logic [31:0] jal_imm;
    logic [31:0] brch_imm;
    logic [31:0] jalr_imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic        halted;
    logic        misalign_err;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0100),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .inst_encoding  (inst_encoding),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .next_pc_sel    (next_pc_sel),
        .br_taken       (br_taken),
        .jal_imm        (jal_imm),
        .brch_imm       (brch_imm),
        .jalr_imm       (jalr_imm),
        .rs1_data       (rs1_data),
        .pc             (pc),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic [2:0]  sel,
                           input logic        br,
                           input logic [31:0] jal,
                           input logic [31:0] brch,
                           input logic [31:0] jalr,
                           input logic [31:0] rs1);
        next_pc_sel = sel;
        br_taken    = br;
        jal_imm     = jal;
        brch_imm    = brch;
        jalr_imm    = jalr;
        rs1_data    = rs1;
    endtask

    // One full fetch starting in S_REQ, with optional stalls
    // on the request, the response and the delivery.
    task automatic do_fetch(input logic [31:0] addr,
                            input logic [31:0] word,
                            input int req_stall,
                            input int wait_cyc,
                            input int dlvr_stall);
        for (int i = 0; i < req_stall; i++) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_addr, addr);
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rdata     = ~word;
            tick();
        end
        imem_rsp_valid = 1'b0;
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr", imem_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_no_req", imem_req_valid, 0);
        for (int i = 0; i < wait_cyc; i++) begin
            chk("wait_inst_valid", inst_valid, 0);
            chk("wait_bus_err", bus_err, 0);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rdata     = word;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < dlvr_stall; i++) begin
            chk("dlvr_hold_valid", inst_valid, 1);
            chk("dlvr_hold_inst", inst_encoding, word);
            chk("dlvr_hold_pc", pc, addr);
            inst_ready     = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rdata     = ~word;
            tick();
            imem_rsp_valid = 1'b0;
        end
        chk("dlvr_valid", inst_valid, 1);
        chk("dlvr_inst", inst_encoding, word);
        chk("dlvr_pc", pc, addr);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic go(input string tag,
                      input logic [31:0] from,
                      input logic [31:0] to);
        do_fetch(from, 32'h0000_0013, 0, 0, 0);
        chk(tag, pc, to);
        chk({tag, "_addr"}, imem_addr, to);
        chk({tag, "_req"}, imem_req_valid, 1);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        set_dec(SEL_P4, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset state
        chk("rst_pc", pc, 32'h100);
        chk("rst_req", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst_encoding, 0);
        chk("rst_halted", halted, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_bus_err", bus_err, 0);

        // Release: one idle cycle, then the first request
        rst = 1'b0;
        chk("idle_req", imem_req_valid, 0);
        tick();
        chk("first_req", imem_req_valid, 1);
        chk("first_addr", imem_addr, 32'h100);

        // Sequential fetch
        do_fetch(32'h100, 32'h0000_0013, 0, 0, 0);
        chk("seq_inst", inst_encoding, 32'h13);
        chk("seq_pc", pc, 32'h104);
        chk("seq_addr", imem_addr, 32'h104);
        chk("seq_req", imem_req_valid, 1);

        // Next-PC selection
        set_dec(SEL_JAL, 0, 32'hFFFF_FFFC, 0, 0, 0);
        go("jal_back", 32'h104, 32'h100);
        set_dec(SEL_JAL, 0, 32'hFFFF_FFF8, 0, 0, 0);
        go("jal_neg", 32'h100, 32'hF8);
        set_dec(SEL_JAL, 0, 32'h8, 0, 0, 0);
        go("jal_pos", 32'hF8, 32'h100);
        set_dec(SEL_BRCH, 1, 0, 32'h20, 0, 0);
        go("br_taken", 32'h100, 32'h120);
        set_dec(SEL_JAL, 0, 32'hFFFF_FFE0, 0, 0, 0);
        go("jal_ret", 32'h120, 32'h100);
        set_dec(SEL_BRCH, 0, 0, 32'h20, 0, 0);
        go("br_not", 32'h100, 32'h104);
        set_dec(SEL_JAL, 0, 32'hFFFF_FEF8, 0, 0, 0);
        go("jal_top", 32'h104, 32'hFFFF_FFFC);
        set_dec(SEL_P4, 1, 32'h40, 32'h80, 32'h10, 32'h30);
        go("wrap", 32'hFFFF_FFFC, 32'h0);
        set_dec(SEL_BAD, 1, 32'h40, 32'h80, 32'h10, 32'h30);
        go("sel_other", 32'h0, 32'h4);
        set_dec(SEL_RF, 0, 32'h40, 32'h80, 32'h4, 32'h2001);
        go("jalr", 32'h4, 32'h2004);

        // Backpressure both sides, response on last wait cycle
        set_dec(SEL_P4, 0, 0, 0, 0, 0);
        do_fetch(32'h2004, 32'h0040_0093, 5, 3, 5);
        chk("bp_pc", pc, 32'h2008);
        chk("bp_no_bus_err", bus_err, 0);
        chk("bp_req", imem_req_valid, 1);

        // Misaligned JALR target halts fetch
        set_dec(SEL_RF, 0, 0, 0, 32'h0, 32'h2003);
        do_fetch(32'h2008, 32'h0000_8067, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("mis_err", misalign_err, 1);
            chk("mis_halted", halted, 1);
            chk("mis_pc", pc, 32'h2002);
            chk("mis_no_req", imem_req_valid, 0);
            chk("mis_no_inst", inst_valid, 0);
            chk("mis_bus_err", bus_err, 0);
            tick();
        end

        // Reset clears the sticky state
        rst = 1'b1;
        tick();
        chk("rst2_misalign", misalign_err, 0);
        chk("rst2_halted", halted, 0);
        chk("rst2_pc", pc, 32'h100);
        rst = 1'b0;
        tick();

        // Response timeout after four wait cycles
        chk("to_req", imem_req_valid, 1);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_not_yet", halted, 0);
            chk("to_no_err_yet", bus_err, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk("to_bus_err", bus_err, 1);
            chk("to_halted", halted, 1);
            chk("to_no_req", imem_req_valid, 0);
            chk("to_pc", pc, 32'h100);
            tick();
        end

        // Reset mid-wait, late response must be ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        chk("late_bus_err", bus_err, 0);
        chk("late_inst", inst_encoding, 0);
        tick();
        tick();
        chk("late_req", imem_req_valid, 1);
        chk("late_addr", imem_addr, 32'h100);
        chk("late_no_inst", inst_valid, 0);
        chk("late_inst2", inst_encoding, 0);
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        set_dec(SEL_P4, 0, 0, 0, 0, 0);
        go("refetch", 32'h100, 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
